// File: rtl/md_sequencer.sv
// ============================================================================
// md_sequencer
//
// Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS
// pipeline. A one-cycle start pulse with a launching md_op captures the
// operands, computes the full 64-bit result immediately into a pending
// register pair, and then holds the unit busy for a fixed per-operation
// latency before committing the pending value to the architectural HI/LO
// registers. mthi/mtlo write HI/LO directly while idle; mfhi/mflo are
// combinational reads of the committed HI/LO.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> md_op 9..12 (madd, maddu, msub, msubu) launch with
//                MULT_CYCLES latency and accumulate into {hi,lo}.
//   undefined -> md_op 9..12 are no-ops; no accumulator logic is built.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (and madd family), >= 1
//   DIV_CYCLES   busy cycles for div/divu, >= 1
//
// Ports:
//   clk         in   1   pipeline clock, all state changes on rising edge
//   reset       in   1   synchronous, active-high
//   start       in   1   E-stage launch pulse
//   md_op       in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                        6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu,
//                        11 msub, 12 msubu
//   src_a       in  32   rs operand (forwarded)
//   src_b       in  32   rt operand (forwarded)
//   md_instr_D  in   1   D-stage instruction is a multiply/divide-class op
//   busy        out  1   operation in flight (registered)
//   stall_md    out  1   md_instr_D & (start | busy)
//   md_out      out 32   hi for mfhi, lo for mflo, else 0
//   hi          out 32   HI register
//   lo          out 32   LO register
// ============================================================================
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_instr_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Opcode classification helpers
    // ------------------------------------------------------------------------
    function automatic logic is_launch(input logic [3:0] op);
        logic hit;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: hit = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: hit = 1'b1;
`endif
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        logic hit;
        case (op)
            OP_DIV, OP_DIVU: hit = 1'b1;
            default:         hit = 1'b0;
        endcase
        return hit;
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             busy_r;

    logic [31:0]      hi_r;
    logic [31:0]      hi_s;
    logic [31:0]      lo_r;
    logic [31:0]      lo_s;
    logic [31:0]      ph_r;
    logic [31:0]      ph_s;
    logic [31:0]      pl_r;
    logic [31:0]      pl_s;
    logic             commit_r;
    logic             commit_s;

    logic             launch_s;
    logic             div_by_zero_s;
    logic [CNT_W-1:0] load_s;
    logic [63:0]      result_s;

    logic [63:0]      prod_signed_s;
    logic [63:0]      prod_unsigned_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [31:0]      a_mag_s;
    logic [31:0]      b_mag_s;
    logic [31:0]      sden_s;
    logic [31:0]      uden_s;
    logic [31:0]      sq_mag_s;
    logic [31:0]      sr_mag_s;
    logic [31:0]      squot_s;
    logic [31:0]      srem_s;
    logic [31:0]      uquot_s;
    logic [31:0]      urem_s;

    // Launch decode: which ops start the sequencer and how long they run.
    always_comb begin
        launch_s      = is_launch(md_op);
        div_by_zero_s = is_div(md_op) & (src_b == 32'd0);
        if (is_div(md_op)) begin
            load_s = DIV_LOAD;
        end else begin
            load_s = MULT_LOAD;
        end
    end

    // Multiply and divide datapath, evaluated on the live E-stage operands.
    always_comb begin
        // The low 64 bits of a product of sign-extended operands equal the
        // signed 32x32 product, so a plain unsigned 64-bit multiply suffices.
        prod_signed_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_unsigned_s = {32'd0, src_a} * {32'd0, src_b};

        // Signed divide through magnitudes: the quotient truncates toward zero
        // and the remainder takes the dividend's sign. 0x80000000 / -1 falls
        // out naturally as magnitude 0x80000000 with a positive sign.
        a_neg_s = src_a[31];
        b_neg_s = src_b[31];
        if (a_neg_s) begin
            a_mag_s = 32'd0 - src_a;
        end else begin
            a_mag_s = src_a;
        end
        if (b_neg_s) begin
            b_mag_s = 32'd0 - src_b;
        end else begin
            b_mag_s = src_b;
        end

        // A zero divisor is replaced by one so the dividers stay well
        // defined; that result is never committed.
        if (src_b == 32'd0) begin
            sden_s = 32'd1;
            uden_s = 32'd1;
        end else begin
            sden_s = b_mag_s;
            uden_s = src_b;
        end

        sq_mag_s = a_mag_s / sden_s;
        sr_mag_s = a_mag_s % sden_s;
        if (a_neg_s ^ b_neg_s) begin
            squot_s = 32'd0 - sq_mag_s;
        end else begin
            squot_s = sq_mag_s;
        end
        if (a_neg_s) begin
            srem_s = 32'd0 - sr_mag_s;
        end else begin
            srem_s = sr_mag_s;
        end

        uquot_s = src_a / uden_s;
        urem_s  = src_a % uden_s;
    end

    // Select the 64-bit pending value {ph,pl} for the launching op.
    always_comb begin
        result_s = 64'd0;
        case (md_op)
            OP_MULT:  result_s = prod_signed_s;
            OP_MULTU: result_s = prod_unsigned_s;
            OP_DIV:   result_s = {srem_s, squot_s};
            OP_DIVU:  result_s = {urem_s, uquot_s};
`ifdef MDU_MADD_EN
            // Accumulate against {hi,lo} as it stands in the launch cycle.
            OP_MADD:  result_s = {hi_r, lo_r} + prod_signed_s;
            OP_MADDU: result_s = {hi_r, lo_r} + prod_unsigned_s;
            OP_MSUB:  result_s = {hi_r, lo_r} - prod_signed_s;
            OP_MSUBU: result_s = {hi_r, lo_r} - prod_unsigned_s;
`endif
            default:  result_s = 64'd0;
        endcase
    end

    // Next-state logic: launch, countdown, commit, and idle mthi/mtlo writes.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ph_s     = ph_r;
        pl_s     = pl_r;
        commit_s = commit_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start && launch_s) begin
                    state_s      = ST_RUN;
                    cnt_s        = load_s;
                    {ph_s, pl_s} = result_s;
                    commit_s     = ~div_by_zero_s;
                end else if (md_op == OP_MTHI) begin
                    hi_s = src_a;
                end else if (md_op == OP_MTLO) begin
                    lo_s = src_a;
                end else begin
                    hi_s = hi_r;
                end
            end
            ST_RUN: begin
                // start and mthi/mtlo are deliberately not looked at here.
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s  = ST_IDLE;
                    commit_s = 1'b0;
                    if (commit_r) begin
                        hi_s = ph_r;
                        lo_s = pl_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                cnt_s    = CNT_ZERO;
                commit_s = 1'b0;
            end
        endcase
    end

    // FSM state, countdown and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    // Architectural HI/LO and the pending result; reset discards pending data.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            ph_r     <= 32'd0;
            pl_r     <= 32'd0;
            commit_r <= 1'b0;
        end else begin
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            ph_r     <= ph_s;
            pl_r     <= pl_s;
            commit_r <= commit_s;
        end
    end

    // mfhi/mflo read the committed registers only, never pending data.
    always_comb begin
        md_out = 32'd0;
        case (md_op)
            OP_MFHI: md_out = hi_r;
            OP_MFLO: md_out = lo_r;
            default: md_out = 32'd0;
        endcase
    end

    assign stall_md = md_instr_D & (start | busy_r);
    assign busy     = busy_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_md_sequencer.sv
// ============================================================================
// tb_md_sequencer
//
// Self-checking bench for md_sequencer. A behavioural model (countdown of
// remaining busy cycles plus 64-bit integer arithmetic) is compared against
// the DUT every cycle; table vectors and hand-written sequences add checks
// against fixed expected constants.
// ============================================================================
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_instr_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sequencer #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md_op      (md_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .md_instr_D (md_instr_D),
        .busy       (busy),
        .stall_md   (stall_md),
        .md_out     (md_out),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Values sampled from the DUT in the most recent cycle.
    logic        s_busy;
    logic        s_stall;
    logic [31:0] s_md;
    logic [31:0] s_hi;
    logic [31:0] s_lo;

    // Reference model state.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_left;
    bit          m_commit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_launches(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
        if (op >= 4'd9 && op <= 4'd12) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit m_is_div(input logic [3:0] op);
        return (op == 4'd3) || (op == 4'd4);
    endfunction

    // Result from plain 64-bit integer arithmetic.
    function automatic logic [63:0] m_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        logic [63:0]     res;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = acc;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd4: begin
                q   = ua / ub;
                r   = ua % ub;
                res = {r[31:0], q[31:0]};
            end
            4'd9:  res = acc + sa * sb;
            4'd10: res = acc + ua * ub;
            4'd11: res = acc - sa * sb;
            4'd12: res = acc - ua * ub;
            default: res = acc;
        endcase
        return res;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        if (reset) begin
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_left   = 0;
            m_commit = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                {m_hi, m_lo} = m_pend;
            end
        end else if (start && m_launches(md_op)) begin
            m_left   = m_is_div(md_op) ? DC : MC;
            m_commit = !(m_is_div(md_op) && src_b == 32'd0);
            if (m_commit) m_pend = m_result(md_op, src_a, src_b, {m_hi, m_lo});
        end else if (md_op == 4'd7) begin
            m_hi = src_a;
        end else if (md_op == 4'd8) begin
            m_lo = src_a;
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, step model.
    task automatic cyc(input logic r, input logic s, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic d);
        logic        exp_busy;
        logic [31:0] exp_md;
        reset      = r;
        start      = s;
        md_op      = op;
        src_a      = a;
        src_b      = b;
        md_instr_D = d;
        @(negedge clk);
        exp_busy = (m_left != 0);
        if (op == 4'd5)      exp_md = m_hi;
        else if (op == 4'd6) exp_md = m_lo;
        else                 exp_md = 32'd0;
        s_busy  = busy;
        s_stall = stall_md;
        s_md    = md_out;
        s_hi    = hi;
        s_lo    = lo;
        chk1("model_busy", busy, exp_busy);
        chk1("model_stall_md", stall_md, d & (s | exp_busy));
        chk("model_md_out", md_out, exp_md);
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h80000000;
            2:       v = 32'hFFFFFFFF;
            3:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs [8];
    int   nb;

    initial begin
        vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vecs[7] = '{4'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DC};

        reset      = 1'b1;
        start      = 1'b0;
        md_op      = 4'd0;
        src_a      = 32'd0;
        src_b      = 32'd0;
        md_instr_D = 1'b0;
        m_hi       = 32'd0;
        m_lo       = 32'd0;
        m_pend     = 64'd0;
        m_left     = 0;
        m_commit   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: stall_md follows md_instr_D & start while held in reset.
        cyc(1'b1, 1'b1, 4'd1, 32'd7, 32'd7, 1'b1);
        chk1("reset_busy", s_busy, 1'b0);
        chk1("reset_stall", s_stall, 1'b1);
        chk("reset_hi", s_hi, 32'd0);
        chk("reset_lo", s_lo, 32'd0);
        idle(1);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            nb = 0;
            cyc(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            for (int k = 0; k < 14; k++) begin
                cyc(1'b0, 1'b0, 4'd0, $urandom, $urandom, 1'b0);
                nb += int'(s_busy);
            end
            chk("vec_busy_cycles", nb, vecs[i].exp_busy);
            chk("vec_hi", s_hi, vecs[i].exp_hi);
            chk("vec_lo", s_lo, vecs[i].exp_lo);
            cyc(1'b0, 1'b0, 4'd5, 32'd0, 32'd0, 1'b0);
            chk("vec_mfhi", s_md, vecs[i].exp_hi);
            cyc(1'b0, 1'b0, 4'd6, 32'd0, 32'd0, 1'b0);
            chk("vec_mflo", s_md, vecs[i].exp_lo);
        end

        // Divide by zero keeps the preloaded HI/LO after a full busy period.
        cyc(1'b0, 1'b0, 4'd7, 32'h11, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd8, 32'h22, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 32'd1234, 32'd0, 1'b0);
        chk("mthi_latency", s_hi, 32'h11);
        chk("mtlo_latency", s_lo, 32'h22);
        nb = 0;
        for (int k = 0; k < 14; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            nb += int'(s_busy);
        end
        chk("divzero_busy_cycles", nb, DC);
        chk("divzero_hi", s_hi, 32'h11);
        chk("divzero_lo", s_lo, 32'h22);

        // Stall covers the start cycle plus the busy window, then releases.
        nb = 0;
        cyc(1'b0, 1'b1, 4'd1, 32'h00012345, 32'h00010000, 1'b1);
        nb += int'(s_stall);
        for (int k = 0; k < MC; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
            nb += int'(s_stall);
        end
        chk("stall_cycles", nb, MC + 1);
        cyc(1'b0, 1'b0, 4'd5, 32'd0, 32'd0, 1'b1);
        chk1("stall_release", s_stall, 1'b0);
        chk("mfhi_after_stall", s_md, 32'h00000001);
        chk("lo_after_stall", s_lo, 32'h23450000);

        // start and mthi while busy are ignored.
        nb = 0;
        cyc(1'b0, 1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 32'd50, 32'd5, 1'b0);
        nb += int'(s_busy);
        cyc(1'b0, 1'b0, 4'd7, 32'h0000DEAD, 32'd0, 1'b0);
        nb += int'(s_busy);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            nb += int'(s_busy);
        end
        chk("busy_ignore_cycles", nb, MC);
        chk("busy_ignore_hi", s_hi, 32'd0);
        chk("busy_ignore_lo", s_lo, 32'd12);

        // Reset in the third busy cycle of a divide aborts with no commit.
        cyc(1'b0, 1'b0, 4'd7, 32'hAAAA5555, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd8, 32'h00001234, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 32'd100, 32'd3, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk1("abort_busy_before", s_busy, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk1("abort_busy", s_busy, 1'b0);
        chk("abort_hi", s_hi, 32'd0);
        chk("abort_lo", s_lo, 32'd0);
        nb = 0;
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            nb += int'(s_busy);
        end
        chk("abort_no_busy", nb, 0);
        chk("abort_no_commit_hi", s_hi, 32'd0);
        chk("abort_no_commit_lo", s_lo, 32'd0);

`ifdef MDU_MADD_EN
        // maddu accumulates onto {hi,lo} sampled at start.
        cyc(1'b0, 1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd8, 32'hFFFFFFFF, 32'd0, 1'b0);
        nb = 0;
        cyc(1'b0, 1'b1, 4'd10, 32'd3, 32'd4, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            nb += int'(s_busy);
        end
        chk("maddu_busy_cycles", nb, MC);
        chk("maddu_hi", s_hi, 32'h00000001);
        chk("maddu_lo", s_lo, 32'h0000000B);
`else
        // Without the accumulate feature, maddu is a no-op.
        cyc(1'b0, 1'b0, 4'd7, 32'h5, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd8, 32'h6, 32'd0, 1'b0);
        nb = 0;
        cyc(1'b0, 1'b1, 4'd10, 32'd3, 32'd4, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            nb += int'(s_busy);
        end
        chk("maddu_noop_busy", nb, 0);
        chk("maddu_noop_hi", s_hi, 32'h5);
        chk("maddu_noop_lo", s_lo, 32'h6);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rrst;
            logic        rst_start;
            logic        rd;
            rop       = 4'($urandom_range(0, 12));
            ra        = pick();
            rb        = pick();
            rrst      = ($urandom_range(0, 299) == 0);
            rst_start = ($urandom_range(0, 2) == 0);
            rd        = 1'($urandom_range(0, 1));
            cyc(rrst, rst_start, rop, ra, rb, rd);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU.
- Accepts a one-cycle start pulse with operands from the E stage.
- Holds the unit busy for a fixed per-operation latency, then commits the result to the architectural HI/LO registers.
- Generates the D-stage stall request that keeps later multiply/divide-class instructions from issuing while the unit is occupied.
- Also serves mthi/mtlo writes and mfhi/mflo reads.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  E-stage pulse launching op 1–4 (and 9–12 with macro)
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu
- src_a  in  32  rs operand (forwarded)
- src_b  in  32  rt operand (forwarded)
- md_instr_D  in  1  D-stage instruction is any md_op 1–12
- busy  out  1  operation in flight
- stall_md  out  1  = md_instr_D & (start | busy)
- md_out  out  32  hi for md_op=5, lo for md_op=6, else 0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN; down-counter cnt, width clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
- IDLE:
  - start with a launching op: latch op and operands, compute the 64-bit result into pending {ph,pl}, load cnt = MULT_CYCLES or DIV_CYCLES, go to RUN.
  - start with any other md_op is ignored.
- RUN: cnt decrements each cycle. On cnt==1, write {hi,lo} ← {ph,pl} and return to IDLE.
- Arithmetic:
  - mult: signed 32×32→64.
  - multu: unsigned 32×32→64.
  - div: lo = truncated quotient, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) → lo=0x80000000, hi=0.
- Divide by zero: runs the full DIV_CYCLES, busy asserted; hi/lo keep their prior values.
- mthi/mtlo (md_op 7/8, no start required) write src_a to hi/lo at the edge, in IDLE only. Ignored in RUN.
- mfhi/mflo are combinational reads of the current hi/lo. They never return pending data.
- start or mthi/mtlo while busy is a protocol violation: ignored, in-flight op unaffected. The hazard unit prevents this through stall_md.

## Timing
- Reset: state IDLE, cnt=0, busy=0, stall_md=md_instr_D&start, hi=0, lo=0, pending discarded. Reset mid-RUN aborts with no commit.
- Start sampled in cycle t:
  - busy=1 in cycles t+1 … t+N.
  - hi/lo hold the new value from cycle t+N+1, when busy=0.
- stall_md is asserted in cycle t (via start) and in t+1 … t+N. The next MD instruction leaves D in cycle t+N+1.
- Back-to-back: a start in cycle t+N+1 is accepted. The first op's result is already visible as its operands/accumulator.
- mthi/mtlo latency is 1: the value is visible on hi/lo in the next cycle.
- md_out has 0 cycles latency from md_op.

## Configuration
- MDU_MADD_EN defined: ops 9–12 launch with MULT_CYCLES latency.
  - madd: {hi,lo} += signed src_a×src_b.
  - maddu: {hi,lo} += unsigned src_a×src_b.
  - msub: {hi,lo} −= signed src_a×src_b.
  - msubu: {hi,lo} −= unsigned src_a×src_b.
  - All accumulate modulo 2^64, using {hi,lo} as sampled at start.
- MDU_MADD_EN undefined: ops 9–12 are no-ops. No busy, hi/lo unchanged, no accumulator logic synthesised.

## Test plan
- mult, src_a=0xFFFFFFFF, src_b=2, MULT_CYCLES=5 → busy high exactly 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu, same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div, src_a=0xFFFFFFF9 (−7), src_b=2 → busy 10 cycles. Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div by zero: start with src_b=0 after hi/lo preloaded via mthi 0x11/mtlo 0x22 → busy 10 cycles. Then hi=0x11, lo=0x22.
- md_instr_D=1 throughout a mult → stall_md high in the start cycle plus 5 busy cycles, low in the following cycle. mfhi in that cycle returns the new hi.
- reset asserted in cycle 3 of a div → next cycle busy=0, hi=lo=0, no later commit. With MDU_MADD_EN, maddu 3×4 on {hi,lo}={0,0xFFFFFFFF} → hi=1, lo=0x0000000B.
